key_conditioner: RTL and testbench
==================================

# key_conditioner

Conditions the raw PMOD/onboard push-button (S1) into clean control events for the LED chaser stage downstream. It synchronises the asynchronous pin, debounces it with a four-state machine and emits a debounced level plus single-cycle press, release, long-press and auto-repeat strobes. It also keeps a wrapping press counter. Its `key_n_clean` output is a drop-in replacement for the raw active-low `key` input of the chaser.

## Interface
Parameters:
- `frequency`, 50_000_000, clk frequency in Hz
- `debounce_ms`, 20, required stable time; DEB = frequency/1000*debounce_ms cycles, must be ≥ 2
- `long_press_ms`, 1000, hold time before `long_press`; LONG = frequency/1000*long_press_ms cycles, ≥ 1
- `repeat_ms`, 200, auto-repeat period after long press; REP = frequency/1000*repeat_ms cycles, ≥ 1
- `key_active_low`, 1, 1 = pin reads 0 when pressed

Ports:
- `clk` input 1 system clock; single clock domain
- `rst` input 1 synchronous, active-high reset
- `key` input 1 raw, asynchronous button pin
- `key_n_clean` output 1 debounced level, active-low (0 = pressed)
- `key_pressed` output 1 debounced level, active-high
- `press_pulse` output 1 one-cycle strobe on debounced press
- `release_pulse` output 1 one-cycle strobe on debounced release
- `long_press` output 1 one-cycle strobe, at most once per press
- `repeat_pulse` output 1 one-cycle strobe every REP cycles after `long_press` while held
- `press_count` output 8 count of debounced presses, wraps 255→0

## Operation
- **Synchroniser:** 2 flops on `key`. Polarity normalisation gives `s` (1 = pressed) = sync2 XOR `key_active_low`.
- **FSM states:**
  - RELEASED: `s`=1 → PRESS_PENDING, and `deb_cnt` is cleared.
  - PRESS_PENDING: `s`=0 → RELEASED (bounce, no output). `deb_cnt`==DEB-1 → PRESSED. Otherwise `deb_cnt`++.
  - PRESSED: `s`=0 → RELEASE_PENDING, and `deb_cnt` is cleared.
  - RELEASE_PENDING: `s`=1 → PRESSED (bounce, no output). `deb_cnt`==DEB-1 → RELEASED. Otherwise `deb_cnt`++.
- **Level outputs:** `key_pressed`=1 in PRESSED and RELEASE_PENDING, else 0. `key_n_clean` is always `~key_pressed`.
- **Edge strobes:**
  - `press_pulse` fires on the PRESS_PENDING→PRESSED transition cycle. `press_count` increments on the same edge.
  - `release_pulse` fires on the RELEASE_PENDING→RELEASED transition.
- **Hold logic:**
  - `hold_cnt` and `rep_cnt` are cleared on entry to PRESSED from PRESS_PENDING.
  - In PRESSED, `hold_cnt` increments until it reaches LONG-1. On that edge `long_press` fires and `hold_cnt` saturates (`long_done` set).
  - After `long_done`, `rep_cnt` counts 0..REP-1 in PRESSED. At REP-1, `repeat_pulse` fires and `rep_cnt` wraps to 0.
  - In RELEASE_PENDING both counters freeze. They resume unchanged if the FSM returns to PRESSED.
- All counters are 32-bit unsigned. No pulse fires while `rst`=1.

## Timing
- **Reset:** on any clk edge with `rst`=1:
  - sync flops are set to the released level;
  - FSM goes to RELEASED and all counters clear;
  - `key_n_clean`=1, `key_pressed`=0, all pulses=0, `press_count`=0.
- **Reset mid-operation:** reset mid-press drops `key_pressed` the next cycle with no `release_pulse`. After reset is released, a still-held key is re-debounced as a new press.
- **Press latency:** with `key` held steady from edge E0 (the first edge sampling the new level), `key_pressed` and `press_pulse` are high after edge E0+DEB+2. Release latency is identical.
- **Bounce tolerance:** any `s` reversal in a PENDING state restarts debouncing.
  - A glitch shorter than DEB cycles produces no output change.
  - A glitch of exactly DEB cycles in `s` is accepted.
- **Long press:** `long_press` is high at edge E_p+LONG-1, where E_p is the edge that asserted `press_pulse`.
- **Auto-repeat:** first `repeat_pulse` comes REP edges after `long_press`, then every REP edges.
- **Simultaneous events:** `repeat_pulse` and the PRESSED→RELEASE_PENDING transition can occur on the same edge; the pulse still fires.
- **Pulse ordering:** pulses are registered, exactly one cycle wide, and never overlap `press_pulse`/`release_pulse` of the same press.

## Test plan
Bench parameters: `frequency`=10_000 (10 cycles/ms), `debounce_ms`=2 (DEB=20), `long_press_ms`=10 (LONG=100), `repeat_ms`=5 (REP=50).

1. **Reset values:** assert `rst` for 3 cycles with `key`=1 → `key_n_clean`=1, `key_pressed`=0, `press_count`=0, no pulses.
2. **Clean press/release:**
   - Stimulus: `key` 1→0 held for 40 cycles, then 1.
   - `press_pulse` exactly one cycle, 22 edges after the first sampling edge; `press_count`=1.
   - `release_pulse` 22 edges after release; no `long_press`.
3. **Bounce rejection:**
   - Stimulus: toggle `key` every 5 cycles for 60 cycles, then hold 0.
   - Exactly one `press_pulse`, 22 edges after the final settle; `press_count`=1.
4. **Long press and repeat:**
   - Stimulus: hold `key`=0 for 300 cycles after `press_pulse`.
   - `long_press` at +99.
   - `repeat_pulse` at +149, +199, +249, +299.
   - `long_press` fires once only.
5. **Counter wrap:** 256 clean presses → `press_count` reads 0. The 257th press reads 1.
6. **Reset mid-press:**
   - Stimulus: hold `key`=0, assert `rst` at hold cycle 50 for 1 cycle.
   - `key_pressed`=0 next cycle with no `release_pulse`.
   - Re-press detected 22 edges after `rst` falls; `press_count`=1.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces a raw push-button pin, then derives
// a clean level plus press/release/long-press/auto-repeat strobes and a press counter.
module key_conditioner #(
    parameter int unsigned frequency      = 50_000_000,
    parameter int unsigned debounce_ms    = 20,
    parameter int unsigned long_press_ms  = 1000,
    parameter int unsigned repeat_ms      = 200,
    parameter bit          key_active_low = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       key_n_clean,
    output logic       key_pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned deb_cycles  = frequency / 1000 * debounce_ms;
    localparam int unsigned long_cycles = frequency / 1000 * long_press_ms;
    localparam int unsigned rep_cycles  = frequency / 1000 * repeat_ms;

    localparam logic [31:0] deb_last = 32'(deb_cycles - 1);
    // The PRESSED entry edge already counts as the first hold cycle, so long_press
    // lands LONG-1 edges after press_pulse.
    localparam logic [31:0] long_tgt = (long_cycles >= 2) ? 32'(long_cycles - 2) : 32'd0;
    localparam logic [31:0] rep_last = 32'(rep_cycles - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressPending,
        StPressed,
        StReleasePending
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [31:0] deb_q, deb_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] rep_q, rep_d;
    logic        long_done_q, long_done_d;
    logic [7:0]  count_q, count_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic        repeat_q, repeat_d;
    logic        s;

    // Normalised pressed level: 1 = button down regardless of pin polarity.
    assign s = sync2_q ^ key_active_low;

    // Two-flop synchroniser; reset parks it at the released pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= key_active_low;
            sync2_q <= key_active_low;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM, hold/repeat counters and registered strobes.
    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        hold_d      = hold_q;
        rep_d       = rep_q;
        long_done_d = long_done_q;
        count_d     = count_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (s) begin
                    state_d = StPressPending;
                    deb_d   = 32'd0;
                end
            end
            StPressPending: begin
                // A full stable window wins over a reversal on the final cycle, so a
                // glitch of exactly DEB cycles is accepted.
                if (deb_q == deb_last) begin
                    state_d     = StPressed;
                    press_d     = 1'b1;
                    count_d     = count_q + 8'd1;
                    hold_d      = 32'd0;
                    rep_d       = 32'd0;
                    long_done_d = 1'b0;
                end else if (!s) begin
                    state_d = StReleased;
                end else begin
                    deb_d = deb_q + 32'd1;
                end
            end
            StPressed: begin
                if (!s) begin
                    state_d = StReleasePending;
                    deb_d   = 32'd0;
                end
                // Hold logic runs on the leaving edge too, so a due strobe still fires.
                if (!long_done_q) begin
                    if (hold_q == long_tgt) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 32'd1;
                    end
                end else begin
                    if (rep_q == rep_last) begin
                        repeat_d = 1'b1;
                        rep_d    = 32'd0;
                    end else begin
                        rep_d = rep_q + 32'd1;
                    end
                end
            end
            StReleasePending: begin
                if (deb_q == deb_last) begin
                    state_d   = StReleased;
                    release_d = 1'b1;
                end else if (s) begin
                    state_d = StPressed;
                end else begin
                    deb_d = deb_q + 32'd1;
                end
            end
            default: state_d = StReleased;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StReleased;
            deb_q       <= 32'd0;
            hold_q      <= 32'd0;
            rep_q       <= 32'd0;
            long_done_q <= 1'b0;
            count_q     <= 8'd0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            long_done_q <= long_done_d;
            count_q     <= count_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    // Level and strobe outputs.
    always_comb begin
        key_pressed   = (state_q == StPressed) || (state_q == StReleasePending);
        key_n_clean   = ~key_pressed;
        press_pulse   = press_q;
        release_pulse = release_q;
        long_press    = long_q;
        repeat_pulse  = repeat_q;
        press_count   = count_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: DEB=20, LONG=100, REP=50 cycles.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       key_n_clean;
    logic       key_pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic [7:0] press_count;

    int checks = 0;
    int failures = 0;

    key_conditioner #(
        .frequency     (10_000),
        .debounce_ms   (2),
        .long_press_ms (10),
        .repeat_ms     (5),
        .key_active_low(1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .key_n_clean  (key_n_clean),
        .key_pressed  (key_pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    // Edge index: at any point after a posedge, cyc is the number of that edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int   n_press = 0, n_release = 0, n_long = 0, n_rep = 0;
    int   press_edge = 0, release_edge = 0, long_edge = 0;
    int   rep_edge[16];
    int   bad_width = 0, overlap = 0;
    logic prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rp = 1'b0;

    always @(negedge clk) begin
        if (press_pulse === 1'b1) begin n_press++; press_edge = cyc; end
        if (release_pulse === 1'b1) begin n_release++; release_edge = cyc; end
        if (long_press === 1'b1) begin n_long++; long_edge = cyc; end
        if (repeat_pulse === 1'b1) begin rep_edge[n_rep % 16] = cyc; n_rep++; end
        if ((press_pulse === 1'b1 && prev_p) || (release_pulse === 1'b1 && prev_r) ||
            (long_press === 1'b1 && prev_l) || (repeat_pulse === 1'b1 && prev_rp))
            bad_width++;
        if ((press_pulse === 1'b1 || release_pulse === 1'b1) &&
            (long_press === 1'b1 || repeat_pulse === 1'b1 ||
             (press_pulse === 1'b1 && release_pulse === 1'b1)))
            overlap++;
        prev_p  = (press_pulse === 1'b1);
        prev_r  = (release_pulse === 1'b1);
        prev_l  = (long_press === 1'b1);
        prev_rp = (repeat_pulse === 1'b1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    int e0, e1, ep, bp, br, bl, brp;

    initial begin
        // 1. Reset values
        rst = 1'b1;
        key = 1'b1;
        tick(3);
        chk("rst_key_n_clean", int'(key_n_clean), 1);
        chk("rst_key_pressed", int'(key_pressed), 0);
        chk("rst_press_count", int'(press_count), 0);
        chk("rst_pulses", int'({press_pulse, release_pulse, long_press, repeat_pulse}), 0);
        chk("rst_pulse_count", n_press + n_release + n_long + n_rep, 0);
        rst = 1'b0;
        tick(2);

        // 2. Clean press and release
        bp = n_press; br = n_release; bl = n_long;
        key = 1'b0;
        e0 = cyc + 1;
        tick(30);
        chk("clean_level_pressed", int'(key_pressed), 1);
        chk("clean_level_n", int'(key_n_clean), 0);
        tick(10);
        key = 1'b1;
        e1 = cyc + 1;
        tick(40);
        chk("clean_press_n", n_press - bp, 1);
        chk("clean_press_edge", press_edge, e0 + 22);
        chk("clean_count", int'(press_count), 1);
        chk("clean_release_n", n_release - br, 1);
        chk("clean_release_edge", release_edge, e1 + 22);
        chk("clean_no_long", n_long - bl, 0);
        chk("clean_released", int'(key_pressed), 0);

        // 3. Bounce rejection
        do_reset();
        bp = n_press;
        key = 1'b1;
        for (int i = 0; i < 12; i++) begin
            key = ~key;
            tick(5);
        end
        chk("bounce_no_press", n_press - bp, 0);
        key = 1'b0;
        e0 = cyc + 1;
        tick(30);
        chk("bounce_press_n", n_press - bp, 1);
        chk("bounce_press_edge", press_edge, e0 + 22);
        chk("bounce_count", int'(press_count), 1);

        // 4. Long press and auto-repeat (key still held from step 3)
        ep = e0 + 22;
        bl = n_long; brp = n_rep; br = n_release;
        tick(ep + 305 - cyc);
        chk("long_n", n_long - bl, 1);
        chk("long_edge", long_edge, ep + 99);
        chk("rep_n", n_rep - brp, 4);
        chk("rep_edge0", rep_edge[(brp + 0) % 16], ep + 149);
        chk("rep_edge1", rep_edge[(brp + 1) % 16], ep + 199);
        chk("rep_edge2", rep_edge[(brp + 2) % 16], ep + 249);
        chk("rep_edge3", rep_edge[(brp + 3) % 16], ep + 299);
        key = 1'b1;
        tick(40);
        chk("long_release_n", n_release - br, 1);
        chk("long_once", n_long - bl, 1);

        // 5. Press counter wrap
        do_reset();
        bp = n_press; bl = n_long;
        for (int i = 0; i < 256; i++) begin
            key = 1'b0;
            tick(30);
            key = 1'b1;
            tick(30);
        end
        chk("wrap_press_n", n_press - bp, 256);
        chk("wrap_count_256", int'(press_count), 0);
        key = 1'b0;
        tick(30);
        key = 1'b1;
        tick(30);
        chk("wrap_count_257", int'(press_count), 1);
        chk("wrap_no_long", n_long - bl, 0);

        // 6. Reset in the middle of a press
        do_reset();
        bp = n_press; br = n_release;
        key = 1'b0;
        e0 = cyc + 1;
        tick(50);
        chk("midrst_pressed_before", int'(key_pressed), 1);
        rst = 1'b1;
        tick(1);
        chk("midrst_dropped", int'(key_pressed), 0);
        chk("midrst_n_clean", int'(key_n_clean), 1);
        chk("midrst_count_clr", int'(press_count), 0);
        rst = 1'b0;
        e1 = cyc + 1;
        tick(30);
        chk("midrst_no_release", n_release - br, 0);
        chk("midrst_press_n", n_press - bp, 2);
        chk("midrst_repress_edge", press_edge, e1 + 22);
        chk("midrst_count", int'(press_count), 1);
        key = 1'b1;
        tick(30);

        chk("pulse_width", bad_width, 0);
        chk("pulse_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
